// File: rtl/bcd_3digit_down_counter_if.sv
// Control, load-value and display signals of the three-digit BCD down counter.
// master drives load/start/stop/tick/wrap and din*; slave presents the counter outputs.
interface bcd_3digit_down_counter_if;
    logic       load;
    logic [3:0] din0;
    logic [3:0] din1;
    logic [3:0] din2;
    logic       start;
    logic       stop;
    logic       tick;
    logic       wrap;
    logic [3:0] out0;
    logic [3:0] out1;
    logic [3:0] out2;
    logic       zero;
    logic       busy;
    logic       done;
    logic       borrow;
    logic       err;

    modport master (
        output load, din0, din1, din2, start, stop, tick, wrap,
        input  out0, out1, out2, zero, busy, done, borrow, err
    );

    modport slave (
        input  load, din0, din1, din2, start, stop, tick, wrap,
        output out0, out1, out2, zero, busy, done, borrow, err
    );
endinterface

// File: rtl/bcd_3digit_down_counter.sv
// Three-digit BCD down counter with load, start/stop, prescaled tick and optional 000->999 wrap.
// One-cycle latency from any input to the registered outputs; no backpressure, inputs are sampled every cycle.
module bcd_3digit_down_counter #(
    parameter int PRESCALE   = 1,
    parameter int PRESCALE_W = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    bcd_3digit_down_counter_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [PRESCALE_W-1:0] PRE_LAST = PRESCALE_W'(PRESCALE - 1);
    localparam logic [PRESCALE_W-1:0] PRE_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_d0, r_d1, r_d2;
    logic [3:0]            w_d0_nxt, w_d1_nxt, w_d2_nxt;
    logic [PRESCALE_W-1:0] r_pre;
    logic [PRESCALE_W-1:0] w_pre_nxt;
    logic                  r_done, r_borrow, r_err;
    logic                  w_done_nxt, w_borrow_nxt, w_err_nxt;

    logic                  w_load_ok;
    logic                  w_is_zero;
    logic                  w_is_one;
    logic [3:0]            w_dec0, w_dec1, w_dec2;
    logic                  w_brw0, w_brw1;

    assign w_load_ok = (bus.din0 <= 4'd9) && (bus.din1 <= 4'd9) && (bus.din2 <= 4'd9);
    assign w_is_zero = (r_d2 == 4'd0) && (r_d1 == 4'd0) && (r_d0 == 4'd0);
    assign w_is_one  = (r_d2 == 4'd0) && (r_d1 == 4'd0) && (r_d0 == 4'd1);

    // Ripple borrow through the digits; only meaningful when the value is non-zero.
    assign w_brw0 = (r_d0 == 4'd0);
    assign w_brw1 = w_brw0 && (r_d1 == 4'd0);
    assign w_dec0 = w_brw0 ? 4'd9 : (r_d0 - 4'd1);
    assign w_dec1 = w_brw0 ? ((r_d1 == 4'd0) ? 4'd9 : (r_d1 - 4'd1)) : r_d1;
    assign w_dec2 = w_brw1 ? ((r_d2 == 4'd0) ? 4'd9 : (r_d2 - 4'd1)) : r_d2;

    always_comb begin
        w_state_nxt  = r_state;
        w_d0_nxt     = r_d0;
        w_d1_nxt     = r_d1;
        w_d2_nxt     = r_d2;
        w_pre_nxt    = r_pre;
        w_done_nxt   = 1'b0;
        w_borrow_nxt = 1'b0;
        w_err_nxt    = 1'b0;

        if (bus.load) begin
            if (!w_load_ok) begin
                w_err_nxt = 1'b1;
            end else begin
                w_d0_nxt    = bus.din0;
                w_d1_nxt    = bus.din1;
                w_d2_nxt    = bus.din2;
                w_state_nxt = ST_IDLE;
                w_pre_nxt   = '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!bus.stop && bus.start) begin
                        if (w_is_zero && !bus.wrap) begin
                            w_state_nxt = ST_DONE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = ST_RUN;
                            w_pre_nxt   = '0;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.stop) begin
                        w_state_nxt = ST_IDLE;
                        w_pre_nxt   = '0;
                    end else if (bus.tick) begin
                        if (r_pre != PRE_LAST) begin
                            w_pre_nxt = r_pre + PRE_ONE;
                        end else begin
                            w_pre_nxt = '0;
                            if (w_is_zero) begin
                                if (bus.wrap) begin
                                    w_d0_nxt     = 4'd9;
                                    w_d1_nxt     = 4'd9;
                                    w_d2_nxt     = 4'd9;
                                    w_borrow_nxt = 1'b1;
                                end else begin
                                    w_state_nxt = ST_DONE;
                                    w_done_nxt  = 1'b1;
                                end
                            end else begin
                                w_d0_nxt = w_dec0;
                                w_d1_nxt = w_dec1;
                                w_d2_nxt = w_dec2;
                                // Reaching 000 with wrap enabled keeps running; the next step wraps.
                                if (w_is_one && !bus.wrap) begin
                                    w_state_nxt = ST_DONE;
                                    w_done_nxt  = 1'b1;
                                end
                            end
                        end
                    end
                end
                ST_DONE: w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_d0     <= 4'd0;
            r_d1     <= 4'd0;
            r_d2     <= 4'd0;
            r_pre    <= '0;
            r_done   <= 1'b0;
            r_borrow <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_d0     <= w_d0_nxt;
            r_d1     <= w_d1_nxt;
            r_d2     <= w_d2_nxt;
            r_pre    <= w_pre_nxt;
            r_done   <= w_done_nxt;
            r_borrow <= w_borrow_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign bus.out0   = r_d0;
    assign bus.out1   = r_d1;
    assign bus.out2   = r_d2;
    assign bus.zero   = w_is_zero;
    assign bus.busy   = (r_state == ST_RUN);
    assign bus.done   = r_done;
    assign bus.borrow = r_borrow;
    assign bus.err    = r_err;
endmodule
